// File: rtl/p4_router_ingress_pkt_arbiter.sv
// Packet-atomic N:1 AXIS arbiter (strict priority / WRR) onto the VNP4 ingress bus.
// Truncates packets longer than MAX_PKT_WORDS and discards the excess beats.
// Ports:
//   clk, areset                 : clock, async active-high reset
//   sched_mode, port_weight     : 0 strict / 1 WRR, per-port WRR weights
//   in_t*                       : NUM_PORTS flattened AXIS slaves
//   out_t*                      : merged AXIS master, tuser = {trunc, src}
//   cnt_clear, pkt_cnt, trunc_cnt : per-port saturating counters
module p4_router_ingress_pkt_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_BYTES    = 64,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int MAX_PKT_WORDS = 24,
  parameter int CNT_WIDTH     = 32,
  localparam int IDX_W =
    (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic clk,
  input  logic areset,
  input  logic sched_mode,
  input  logic [NUM_PORTS*WEIGHT_WIDTH-1:0] port_weight,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0] in_tdata,
  input  logic [NUM_PORTS*DATA_BYTES-1:0] in_tkeep,
  input  logic [NUM_PORTS-1:0] in_tvalid,
  input  logic [NUM_PORTS-1:0] in_tlast,
  output logic [NUM_PORTS-1:0] in_tready,
  output logic [DATA_BYTES*8-1:0] out_tdata,
  output logic [DATA_BYTES-1:0] out_tkeep,
  output logic [IDX_W:0] out_tuser,
  output logic out_tvalid,
  output logic out_tlast,
  input  logic out_tready,
  input  logic [NUM_PORTS-1:0] cnt_clear,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_cnt,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] trunc_cnt
);

  localparam int DW   = DATA_BYTES * 8;
  localparam int BC_W = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic [1:0] {
    ARB, FWD, DISCARD
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0] grant, last_grant;
  logic [IDX_W-1:0] pick, idx;
  logic pick_ok, reload;
  logic [NUM_PORTS-1:0][WEIGHT_WIDTH-1:0] credit;
  logic [NUM_PORTS-1:0][WEIGHT_WIDTH-1:0] wt_v;
  logic [NUM_PORTS-1:0][DW-1:0] data_v;
  logic [NUM_PORTS-1:0][DATA_BYTES-1:0] keep_v;
  logic [NUM_PORTS-1:0] elig, wt_nz;
  logic [BC_W-1:0] beat_cnt;
  logic out_free, acc, sel_last;
  logic last_beat, trunc, pkt_done;

  assign wt_v   = port_weight;
  assign data_v = in_tdata;
  assign keep_v = in_tkeep;

  assign out_free  = !out_tvalid || out_tready;
  assign sel_last  = in_tlast[grant];
  assign acc       = in_tvalid[grant] &&
                     ((state == FWD && out_free) ||
                      state == DISCARD);
  assign last_beat =
    beat_cnt == BC_W'(MAX_PKT_WORDS - 1);
  assign trunc     = state == FWD && acc &&
                     last_beat && !sel_last;
  assign pkt_done  = state == FWD && acc &&
                     (sel_last || last_beat);

  always_comb begin
    in_tready = '0;
    if ((state == FWD && out_free) ||
        state == DISCARD)
      in_tready[grant] = 1'b1;
  end

  // Strict: lowest valid index. WRR: circular scan
  // starting just after the previous packet's source.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = last_grant;
    for (int i = 0; i < NUM_PORTS; i++) begin
      wt_nz[i] = |wt_v[i];
      elig[i]  = in_tvalid[i] &&
                 (!sched_mode || credit[i] != '0);
    end
    if (!sched_mode) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--)
        if (elig[i]) begin
          pick    = IDX_W'(i);
          pick_ok = 1'b1;
        end
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (idx == IDX_W'(NUM_PORTS - 1))
          idx = '0;
        else
          idx = idx + IDX_W'(1);
        if (!pick_ok && elig[idx]) begin
          pick    = idx;
          pick_ok = 1'b1;
        end
      end
    end
    // Credits exhausted but a weighted port waits:
    // refill now, grant on the next ARB cycle.
    reload = sched_mode && !pick_ok &&
             |(in_tvalid & wt_nz);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB:
        if (pick_ok) state_nxt = FWD;
      FWD:
        if (acc && sel_last) state_nxt = ARB;
        else if (trunc) state_nxt = DISCARD;
      DISCARD:
        if (acc && sel_last) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= ARB;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
      credit     <= '0;
      beat_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB) begin
        if (reload) begin
          credit <= wt_v;
        end else if (pick_ok) begin
          grant    <= pick;
          beat_cnt <= '0;
          if (sched_mode)
            credit[pick] <= credit[pick] -
                            WEIGHT_WIDTH'(1);
        end
      end
      if (acc) begin
        if (state == FWD)
          beat_cnt <= beat_cnt + BC_W'(1);
        if (sel_last)
          last_grant <= grant;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tuser  <= '0;
      out_tlast  <= 1'b0;
    end else if (state == FWD && acc) begin
      out_tvalid <= 1'b1;
      out_tdata  <= data_v[grant];
      out_tkeep  <= keep_v[grant];
      out_tuser  <= {trunc, grant};
      out_tlast  <= sel_last || last_beat;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end

  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] pkt_q;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] trunc_q;

  assign pkt_cnt   = pkt_q;
  assign trunc_cnt = trunc_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
    logic hit;
    assign hit = grant == IDX_W'(i);

    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        pkt_q[i]   <= '0;
        trunc_q[i] <= '0;
      end else if (cnt_clear[i]) begin
        pkt_q[i]   <= '0;
        trunc_q[i] <= '0;
      end else begin
        if (hit && pkt_done && pkt_q[i] != '1)
          pkt_q[i] <= pkt_q[i] + CNT_WIDTH'(1);
        if (hit && trunc && trunc_q[i] != '1)
          trunc_q[i] <= trunc_q[i] + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_p4_router_ingress_pkt_arbiter.sv
// Scoreboard bench for p4_router_ingress_pkt_arbiter.
// Directed packets; a negedge monitor pops and compares output beats.
module tb_p4_router_ingress_pkt_arbiter;

  localparam int NP = 4;
  localparam int DB = 4;
  localparam int WW = 4;
  localparam int MPW = 24;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic areset;
  logic sched_mode;
  logic [NP*WW-1:0] port_weight;
  logic [NP*DB*8-1:0] in_tdata;
  logic [NP*DB-1:0] in_tkeep;
  logic [NP-1:0] in_tvalid, in_tlast, in_tready;
  logic [DB*8-1:0] out_tdata;
  logic [DB-1:0] out_tkeep;
  logic [2:0] out_tuser;
  logic out_tvalid, out_tlast, out_tready;
  logic [NP-1:0] cnt_clear;
  logic [NP*CW-1:0] pkt_cnt, trunc_cnt;

  p4_router_ingress_pkt_arbiter #(
    .NUM_PORTS(NP), .DATA_BYTES(DB),
    .WEIGHT_WIDTH(WW), .MAX_PKT_WORDS(MPW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .areset(areset),
    .sched_mode(sched_mode),
    .port_weight(port_weight),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep),
    .out_tuser(out_tuser), .out_tvalid(out_tvalid),
    .out_tlast(out_tlast), .out_tready(out_tready),
    .cnt_clear(cnt_clear),
    .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic [2:0]  u;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int beat_cyc[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_pkt[NP];
  int exp_trunc[NP];
  bit chk_rdy = 0;
  bit hold_v = 0;
  logic [40:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dat(
    int p, int tag, int b);
    return {8'(p), 8'(tag), 16'(b)};
  endfunction

  // Monitor: stability under stall, in_tready
  // backpressure, and scoreboard comparison.
  always @(negedge clk) begin
    exp_t e;
    logic [40:0] cur;
    cur = {out_tvalid, out_tdata, out_tkeep,
           out_tuser, out_tlast};
    if (hold_v) begin
      n_chk++;
      if (cur != held) begin
        n_fail++;
        $display("FAIL stall_stable got %h want %h",
                 cur, held);
      end
    end
    hold_v = out_tvalid && !out_tready && !areset;
    held = cur;
    if (chk_rdy && out_tvalid && !out_tready) begin
      n_chk++;
      if (in_tready != '0) begin
        n_fail++;
        $display("FAIL ready_while_full got %b want 0",
                 in_tready);
      end
    end
    if (out_tvalid && out_tready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat got d=%h u=%0d",
                 out_tdata, out_tuser);
      end else begin
        e = sb.pop_front();
        beat_cyc.push_back(cyc);
        if (out_tdata !== e.d || out_tkeep !== e.k ||
            out_tuser !== e.u || out_tlast !== e.l) begin
          n_fail++;
          $display({"FAIL beat got d=%h k=%h u=%0d l=%b",
                    " want d=%h k=%h u=%0d l=%b"},
                   out_tdata, out_tkeep, out_tuser,
                   out_tlast, e.d, e.k, e.u, e.l);
        end
      end
    end
  end

  task automatic send_beat(input int p,
      input logic [31:0] d, input logic [3:0] k,
      input logic l, input logic clr);
    int t;
    in_tdata[p*32 +: 32] = d;
    in_tkeep[p*4 +: 4] = k;
    in_tlast[p] = l;
    in_tvalid[p] = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_tready[p] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_tready[p]) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout port %0d got 0 want 1", p);
    end else begin
      if (clr) cnt_clear[p] = 1'b1;
      @(posedge clk);
      #1;
      cnt_clear[p] = 1'b0;
    end
    in_tvalid[p] = 1'b0;
  endtask

  task automatic push_pkt(input int p, input int n,
      input int tag);
    exp_t e;
    int nf;
    bit tr;
    tr = n > MPW;
    nf = tr ? MPW : n;
    for (int b = 0; b < nf; b++) begin
      e.d = dat(p, tag, b);
      e.k = (b == n - 1) ? 4'h3 : 4'hF;
      e.u = {tr && b == nf - 1, 2'(p)};
      e.l = b == nf - 1;
      sb.push_back(e);
    end
    if (exp_pkt[p] < 15) exp_pkt[p]++;
    if (tr && exp_trunc[p] < 15) exp_trunc[p]++;
  endtask

  task automatic drive_pkt(input int p, input int n,
      input int tag, input logic clr);
    for (int b = 0; b < n; b++)
      send_beat(p, dat(p, tag, b),
                (b == n - 1) ? 4'h3 : 4'hF,
                b == n - 1, clr && b == n - 1);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d left want 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    for (int p = 0; p < NP; p++) begin
      n_chk += 2;
      if (pkt_cnt[p*CW +: CW] !== CW'(exp_pkt[p])) begin
        n_fail++;
        $display("FAIL %s pkt_cnt[%0d] got %0d want %0d",
                 tag, p, pkt_cnt[p*CW +: CW], exp_pkt[p]);
      end
      if (trunc_cnt[p*CW +: CW] !== CW'(exp_trunc[p])) begin
        n_fail++;
        $display("FAIL %s trunc_cnt[%0d] got %0d want %0d",
                 tag, p, trunc_cnt[p*CW +: CW],
                 exp_trunc[p]);
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    n_chk++;
    if ({out_tvalid, out_tdata, out_tkeep, out_tuser,
         out_tlast, in_tready} != '0) begin
      n_fail++;
      $display("FAIL %s outputs got v=%b d=%h u=%0d r=%b want 0",
               tag, out_tvalid, out_tdata, out_tuser,
               in_tready);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int wp[12] = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    int k0, k1;
    areset = 1'b1;
    sched_mode = 1'b0;
    port_weight = 16'h0013;
    in_tdata = '0;
    in_tkeep = '0;
    in_tvalid = '0;
    in_tlast = '0;
    out_tready = 1'b1;
    cnt_clear = '0;
    for (int p = 0; p < NP; p++) begin
      exp_pkt[p] = 0;
      exp_trunc[p] = 0;
    end
    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk_cnt("reset");
    areset = 1'b0;

    // strict: ports 0 and 2 together
    beat_cyc.delete();
    push_pkt(0, 3, 1);
    push_pkt(2, 3, 1);
    fork
      drive_pkt(0, 3, 1, 1'b0);
      drive_pkt(2, 3, 1, 1'b0);
    join
    wait_drain();
    n_chk++;
    if (beat_cyc.size() != 6) begin
      n_fail++;
      $display("FAIL strict_beats got %0d want 6",
               beat_cyc.size());
    end else if (beat_cyc[3] - beat_cyc[2] != 2) begin
      n_fail++;
      $display("FAIL strict_gap got %0d want 2",
               beat_cyc[3] - beat_cyc[2]);
    end
    chk_cnt("strict");

    // WRR weights {3,1,0,0}; port 2 valid, weight 0
    sched_mode = 1'b1;
    in_tdata[64 +: 32] = 32'hDEAD_0002;
    in_tkeep[8 +: 4] = 4'hF;
    in_tlast[2] = 1'b1;
    in_tvalid[2] = 1'b1;
    k0 = 0;
    k1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (wp[i] == 0) begin
        push_pkt(0, 1, 16 + k0);
        k0++;
      end else begin
        push_pkt(1, 1, 16 + k1);
        k1++;
      end
    end
    fork
      for (int k = 0; k < 9; k++)
        drive_pkt(0, 1, 16 + k, 1'b0);
      for (int k = 0; k < 3; k++)
        drive_pkt(1, 1, 16 + k, 1'b0);
    join
    wait_drain();
    in_tvalid[2] = 1'b0;
    sched_mode = 1'b0;
    chk_cnt("wrr");

    // truncation then a normal packet
    push_pkt(1, 30, 32);
    drive_pkt(1, 30, 32, 1'b0);
    push_pkt(1, 2, 33);
    drive_pkt(1, 2, 33, 1'b0);
    wait_drain();
    chk_cnt("trunc");

    // 50% output backpressure
    chk_rdy = 1;
    push_pkt(3, 5, 48);
    fork
      begin
        drive_pkt(3, 5, 48, 1'b0);
        repeat (3) @(posedge clk);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(posedge clk);
          #1;
          out_tready = ~out_tready;
        end
      end
    join
    out_tready = 1'b1;
    wait_drain();
    chk_rdy = 0;
    chk_cnt("stall");

    // reset mid-packet after beat 2
    for (int b = 0; b < 2; b++)
      sb.push_back('{dat(0, 64, b), 4'hF, 3'd0, 1'b0});
    send_beat(0, dat(0, 64, 0), 4'hF, 1'b0, 1'b0);
    send_beat(0, dat(0, 64, 1), 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    areset = 1'b1;
    #1;
    chk_zero("midreset");
    for (int p = 0; p < NP; p++) begin
      exp_pkt[p] = 0;
      exp_trunc[p] = 0;
    end
    chk_cnt("midreset");
    repeat (2) @(negedge clk);
    areset = 1'b0;
    push_pkt(3, 1, 80);
    drive_pkt(3, 1, 80, 1'b0);
    wait_drain();
    chk_cnt("after_reset");

    // saturation at all-ones, then clear vs tlast
    for (int k = 0; k < 16; k++) begin
      push_pkt(0, 1, 96 + k);
      drive_pkt(0, 1, 96 + k, 1'b0);
    end
    wait_drain();
    chk_cnt("saturate");
    push_pkt(0, 1, 120);
    drive_pkt(0, 1, 120, 1'b1);
    exp_pkt[0] = 0;
    wait_drain();
    chk_cnt("clear");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
